// File: rtl/img_io_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : img_io_pkg
//  Description : Shared definitions for the image byte-stream serialiser.
//                Holds the ASCII constants, the hex-digit encoder and the
//                serialiser state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package img_io_pkg;

    // ASCII bytes used as pixel and row separators in text mode
    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_LF    = 8'h0A;

    // Serialiser states: waiting for a pixel, emitting digits/bytes, emitting separator
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        SEP  = 2'd2
    } state_t;

    // Lowercase hex digit for one nibble: '0'-'9' then 'a'-'f'
    function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
        if (nibble < 4'd10) begin
            return 8'h30 + {4'h0, nibble};
        end
        return 8'h57 + {4'h0, nibble};
    endfunction

endpackage : img_io_pkg
`default_nettype wire

// File: rtl/binary_image_text_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : binary_image_text_streamer
//  Description : Serialises a raster pixel stream into a byte stream, either
//                as lowercase hex text (space between pixels, LF per row) or
//                as packed big-endian raw bytes. Valid/ready on both sides,
//                m_last on the final byte of a frame and a frame_done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module binary_image_text_streamer
    import img_io_pkg::*;
#(
    parameter int WIDTH  = 1920,
    parameter int HEIGHT = 1080,
    parameter int PIX_W  = 8,
    parameter int MODE   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             m_last,
    output logic             frame_done
);

    localparam int NDIG  = (PIX_W + 3) / 4;
    localparam int NBYTE = (PIX_W + 7) / 8;
    localparam int NUNIT = (MODE == 1) ? NBYTE : NDIG;
    localparam int MAXU  = (NDIG > NBYTE) ? NDIG : NBYTE;
    localparam int CW    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int IW    = (MAXU   > 1) ? $clog2(MAXU)   : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUNIT - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic              frame_done_q, frame_done_d;

    logic              w_last_col;
    logic              w_last_row;
    logic              w_last_idx;
    logic              w_finish;
    logic [4*NDIG-1:0] w_hex_ext;
    logic [8*NBYTE-1:0] w_raw_ext;
    logic [3:0]        w_nibble;
    logic [7:0]        w_raw_byte;
    logic [7:0]        w_unit_byte;

    assign w_last_col = (col_q == COL_LAST);
    assign w_last_row = (row_q == ROW_LAST);
    assign w_last_idx = (idx_q == IDX_LAST);

    // Digit/byte selector: idx 0 addresses the most significant unit
    always_comb begin
        w_hex_ext              = '0;
        w_hex_ext[PIX_W-1:0]   = pix_q;
        w_raw_ext              = '0;
        w_raw_ext[PIX_W-1:0]   = pix_q;
        w_nibble               = '0;
        w_raw_byte             = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (idx_q == IW'(NDIG - 1 - k)) begin
                w_nibble = w_hex_ext[4*k +: 4];
            end
        end
        for (int k = 0; k < NBYTE; k++) begin
            if (idx_q == IW'(NBYTE - 1 - k)) begin
                w_raw_byte = w_raw_ext[8*k +: 8];
            end
        end
        w_unit_byte = (MODE == 1) ? w_raw_byte : hex_ascii(w_nibble);
    end

    // Output stage decoded from the registered state, so it is stable under stall
    always_comb begin
        s_ready    = (state_q == IDLE);
        m_valid    = (state_q != IDLE);
        m_data     = 8'h00;
        m_last     = 1'b0;
        frame_done = frame_done_q;
        case (state_q)
            EMIT: begin
                m_data = w_unit_byte;
                m_last = (MODE == 1) && w_last_idx && w_last_col && w_last_row;
            end
            SEP: begin
                m_data = w_last_col ? ASC_LF : ASC_SPACE;
                m_last = w_last_col && w_last_row;
            end
            default: begin
                m_data = 8'h00;
                m_last = 1'b0;
            end
        endcase
    end

    // Next-state logic: pixel capture, unit stepping and raster position update
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        idx_d        = idx_q;
        pix_d        = pix_q;
        frame_done_d = 1'b0;
        w_finish     = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    pix_d   = s_data;
                    idx_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (m_ready) begin
                    if (!w_last_idx) begin
                        idx_d = idx_q + 1'b1;
                    end else if (MODE == 0) begin
                        state_d = SEP;
                    end else begin
                        w_finish = 1'b1;
                    end
                end
            end
            SEP: begin
                if (m_ready) begin
                    w_finish = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (w_finish) begin
            idx_d   = '0;
            state_d = IDLE;
            if (w_last_col) begin
                col_d = '0;
                if (w_last_row) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // State and counter registers; reset drops any in-flight pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            idx_q        <= '0;
            pix_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            idx_q        <= idx_d;
            pix_q        <= pix_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule : binary_image_text_streamer
`default_nettype wire
